// File: rtl/ccip_c0_req_mux_if.sv
// C0 read-request and read-response bundle between the requester channels,
// the FIU port and ccip_c0_req_mux.
interface ccip_c0_req_mux_if #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned HDR_W   = 64,
  parameter int unsigned MDATA_W = 16,
  parameter int unsigned DATA_W  = 512
);
  logic [N_CH-1:0]         ch_req_valid;
  logic [N_CH*HDR_W-1:0]   ch_req_hdr;
  logic [N_CH*MDATA_W-1:0] ch_req_mdata;
  logic [N_CH-1:0]         ch_almost_full;
  logic                    out_req_valid;
  logic [HDR_W-1:0]        out_req_hdr;
  logic [MDATA_W-1:0]      out_req_mdata;
  logic                    out_almost_full;
  logic                    rsp_valid;
  logic [MDATA_W-1:0]      rsp_mdata;
  logic [DATA_W-1:0]       rsp_data;
  logic [N_CH-1:0]         ch_rsp_valid;
  logic [MDATA_W-1:0]      ch_rsp_mdata;
  logic [DATA_W-1:0]       ch_rsp_data;
  logic [N_CH-1:0]         err_overflow;
  logic                    err_rsp_tag;

  modport slave (
    input  ch_req_valid, ch_req_hdr, ch_req_mdata, out_almost_full,
    input  rsp_valid, rsp_mdata, rsp_data,
    output ch_almost_full, out_req_valid, out_req_hdr, out_req_mdata,
    output ch_rsp_valid, ch_rsp_mdata, ch_rsp_data, err_overflow, err_rsp_tag
  );

  modport master (
    output ch_req_valid, ch_req_hdr, ch_req_mdata, out_almost_full,
    output rsp_valid, rsp_mdata, rsp_data,
    input  ch_almost_full, out_req_valid, out_req_hdr, out_req_mdata,
    input  ch_rsp_valid, ch_rsp_mdata, ch_rsp_data, err_overflow, err_rsp_tag
  );
endinterface

// File: rtl/ccip_c0_req_mux.sv
// N-channel CCI-P C0 read-request mux: per-channel FIFOs, round-robin merge honouring
// FIU almost-full, channel ID tagged into upper mdata and used to route responses back.
module ccip_c0_req_mux #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned HDR_W      = 64,
  parameter int unsigned MDATA_W    = 16,
  parameter int unsigned DATA_W     = 512,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned AF_SLACK   = 2
) (
  input logic              pClk,
  input logic              pReset_n,
  ccip_c0_req_mux_if.slave io_bus
);
  localparam int unsigned CH_W  = ($clog2(N_CH) > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned LO_W  = MDATA_W - CH_W;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [HDR_W-1:0]   r_hdr_mem [N_CH][FIFO_DEPTH];
  logic [LO_W-1:0]    r_md_mem  [N_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wptr    [N_CH];
  logic [PTR_W-1:0]   r_rptr    [N_CH];
  logic [CNT_W-1:0]   r_cnt     [N_CH];
  logic [CH_W-1:0]    r_rr_ptr;
  logic               r_out_valid;
  logic [HDR_W-1:0]   r_out_hdr;
  logic [MDATA_W-1:0] r_out_mdata;
  logic [N_CH-1:0]    r_err_ovf;
  logic [N_CH-1:0]    r_rsp_valid;
  logic [MDATA_W-1:0] r_rsp_mdata;
  logic [DATA_W-1:0]  r_rsp_data;
  logic               r_err_tag;

  logic [N_CH-1:0]    w_nonempty;
  logic [N_CH-1:0]    w_full;
  logic [N_CH-1:0]    w_push;
  logic [N_CH-1:0]    w_pop;
  logic [N_CH-1:0]    w_ovf;
  logic [N_CH-1:0]    w_af;
  logic [CH_W-1:0]    w_idx;
  logic [CH_W-1:0]    w_gnt;
  logic               w_gnt_valid;
  logic [HDR_W-1:0]   w_head_hdr;
  logic [LO_W-1:0]    w_head_md;
  logic [CH_W-1:0]    w_rsp_ch;
  logic [N_CH-1:0]    w_rsp_hit;
  logic               w_unused_md;

  // Round-robin search starting at r_rr_ptr; almost-full blocks the grant in the same cycle.
  always_comb begin
    w_gnt_valid = 1'b0;
    w_gnt       = '0;
    w_idx       = '0;
    for (int i = 0; i < N_CH; i++) begin
      w_nonempty[i] = (r_cnt[i] != '0);
    end
    if (!io_bus.out_almost_full) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        w_idx = CH_W'((32'(r_rr_ptr) + k) % N_CH);
        if (!w_gnt_valid && w_nonempty[w_idx]) begin
          w_gnt_valid = 1'b1;
          w_gnt       = w_idx;
        end
      end
    end
  end

  always_comb begin
    w_pop = '0;
    if (w_gnt_valid) begin
      w_pop[w_gnt] = 1'b1;
    end
    for (int i = 0; i < N_CH; i++) begin
      w_full[i] = (r_cnt[i] == CNT_W'(FIFO_DEPTH));
      w_push[i] = io_bus.ch_req_valid[i] && (!w_full[i] || w_pop[i]);
      w_ovf[i]  = io_bus.ch_req_valid[i] && w_full[i] && !w_pop[i];
      w_af[i]   = (r_cnt[i] >= CNT_W'(FIFO_DEPTH - AF_SLACK));
    end
    w_head_hdr = r_hdr_mem[w_gnt][r_rptr[w_gnt]];
    w_head_md  = r_md_mem[w_gnt][r_rptr[w_gnt]];
  end

  // The channel's own upper mdata bits are overwritten by the tag.
  always_comb begin
    w_unused_md = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      w_unused_md = w_unused_md ^ (^io_bus.ch_req_mdata[i*MDATA_W+LO_W +: CH_W]);
    end
  end

  always_ff @(posedge pClk) begin
    for (int i = 0; i < N_CH; i++) begin
      if (w_push[i]) begin
        r_hdr_mem[i][r_wptr[i]] <= io_bus.ch_req_hdr[i*HDR_W +: HDR_W];
        r_md_mem[i][r_wptr[i]]  <= io_bus.ch_req_mdata[i*MDATA_W +: LO_W];
      end
    end
  end

  always_ff @(posedge pClk) begin
    if (!pReset_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
        r_cnt[i]  <= '0;
      end
      r_rr_ptr    <= '0;
      r_out_valid <= 1'b0;
      r_out_hdr   <= '0;
      r_out_mdata <= '0;
      r_err_ovf   <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        if (w_push[i]) begin
          r_wptr[i] <= r_wptr[i] + 1'b1;
        end
        if (w_pop[i]) begin
          r_rptr[i] <= r_rptr[i] + 1'b1;
        end
        if (w_push[i] && !w_pop[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (!w_push[i] && w_pop[i]) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
      r_err_ovf   <= r_err_ovf | w_ovf;
      r_out_valid <= w_gnt_valid;
      if (w_gnt_valid) begin
        r_rr_ptr    <= (w_gnt == CH_W'(N_CH - 1)) ? '0 : w_gnt + 1'b1;
        r_out_hdr   <= w_head_hdr;
        r_out_mdata <= {w_gnt, w_head_md};
      end
    end
  end

  // Response routing is stateless apart from the output register.
  assign w_rsp_ch = io_bus.rsp_mdata[MDATA_W-1 -: CH_W];

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      w_rsp_hit[i] = io_bus.rsp_valid && (w_rsp_ch == CH_W'(i));
    end
  end

  always_ff @(posedge pClk) begin
    if (!pReset_n) begin
      r_rsp_valid <= '0;
      r_rsp_mdata <= '0;
      r_rsp_data  <= '0;
      r_err_tag   <= 1'b0;
    end else begin
      r_rsp_valid <= w_rsp_hit;
      if (|w_rsp_hit) begin
        r_rsp_mdata <= {{CH_W{1'b0}}, io_bus.rsp_mdata[LO_W-1:0]};
        r_rsp_data  <= io_bus.rsp_data;
      end else if (io_bus.rsp_valid) begin
        r_err_tag <= 1'b1;
      end
    end
  end

  assign io_bus.ch_almost_full = w_af;
  assign io_bus.out_req_valid  = r_out_valid;
  assign io_bus.out_req_hdr    = r_out_hdr;
  assign io_bus.out_req_mdata  = r_out_mdata;
  assign io_bus.err_overflow   = r_err_ovf;
  assign io_bus.ch_rsp_valid   = r_rsp_valid;
  assign io_bus.ch_rsp_mdata   = r_rsp_mdata;
  assign io_bus.ch_rsp_data    = r_rsp_data;
  assign io_bus.err_rsp_tag    = r_err_tag;
endmodule

// File: tb/tb_ccip_c0_req_mux.sv
// Directed bench for ccip_c0_req_mux: request order is scoreboarded through a queue,
// a second 3-channel instance covers the out-of-range response tag.
module tb_ccip_c0_req_mux;
  localparam int unsigned N_CH       = 4;
  localparam int unsigned N3         = 3;
  localparam int unsigned HDR_W      = 64;
  localparam int unsigned MDATA_W    = 16;
  localparam int unsigned DATA_W     = 512;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned AF_SLACK   = 2;

  typedef struct packed {
    logic [HDR_W-1:0]   hdr;
    logic [MDATA_W-1:0] mdata;
  } req_t;

  logic pClk = 1'b0;
  logic pReset_n;
  int   checks = 0;
  int   errors = 0;
  req_t exp_q[$];
  logic [DATA_W-1:0] d1, d2, d3;

  ccip_c0_req_mux_if #(.N_CH(N_CH), .HDR_W(HDR_W), .MDATA_W(MDATA_W), .DATA_W(DATA_W)) bus ();
  ccip_c0_req_mux_if #(.N_CH(N3), .HDR_W(HDR_W), .MDATA_W(MDATA_W), .DATA_W(DATA_W)) bus3 ();

  ccip_c0_req_mux #(
    .N_CH(N_CH), .HDR_W(HDR_W), .MDATA_W(MDATA_W), .DATA_W(DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH), .AF_SLACK(AF_SLACK)
  ) u_dut (.pClk(pClk), .pReset_n(pReset_n), .io_bus(bus));

  ccip_c0_req_mux #(
    .N_CH(N3), .HDR_W(HDR_W), .MDATA_W(MDATA_W), .DATA_W(DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH), .AF_SLACK(AF_SLACK)
  ) u_dut3 (.pClk(pClk), .pReset_n(pReset_n), .io_bus(bus3));

  always #5 pClk = ~pClk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_reqs();
    bus.ch_req_valid = '0;
  endtask

  task automatic clear_inputs();
    bus.ch_req_valid     = '0;
    bus.ch_req_hdr       = '0;
    bus.ch_req_mdata     = '0;
    bus.out_almost_full  = 1'b0;
    bus.rsp_valid        = 1'b0;
    bus.rsp_mdata        = '0;
    bus.rsp_data         = '0;
    bus3.ch_req_valid    = '0;
    bus3.ch_req_hdr      = '0;
    bus3.ch_req_mdata    = '0;
    bus3.out_almost_full = 1'b0;
    bus3.rsp_valid       = 1'b0;
    bus3.rsp_mdata       = '0;
    bus3.rsp_data        = '0;
  endtask

  // Drive a push on channel ch; when it is expected to issue, queue the tagged request.
  task automatic push(input int ch, input logic [HDR_W-1:0] hdr, input logic [MDATA_W-1:0] md,
                      input bit expect_out);
    req_t e;
    bus.ch_req_valid[ch]                   = 1'b1;
    bus.ch_req_hdr[ch*HDR_W +: HDR_W]      = hdr;
    bus.ch_req_mdata[ch*MDATA_W +: MDATA_W] = md;
    if (expect_out) begin
      e.hdr   = hdr;
      e.mdata = {2'(ch), md[13:0]};
      exp_q.push_back(e);
    end
  endtask

  task automatic do_reset();
    pReset_n = 1'b0;
    exp_q.delete();
    @(negedge pClk);
    pReset_n = 1'b1;
  endtask

  // Scoreboard: every issued request must match the head of the expected queue.
  always @(negedge pClk) begin
    req_t e;
    if (bus.out_req_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("req_unexpected", bus.out_req_valid, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("req_hdr", bus.out_req_hdr, e.hdr);
        chk("req_mdata", bus.out_req_mdata, e.mdata);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    pReset_n = 1'b0;
    repeat (2) @(negedge pClk);
    chk("rst_out_valid", bus.out_req_valid, 1'b0);
    chk("rst_out_hdr", bus.out_req_hdr, '0);
    chk("rst_out_mdata", bus.out_req_mdata, '0);
    chk("rst_ch_af", bus.ch_almost_full, '0);
    chk("rst_rsp_valid", bus.ch_rsp_valid, '0);
    chk("rst_rsp_mdata", bus.ch_rsp_mdata, '0);
    chk("rst_rsp_data", bus.ch_rsp_data, '0);
    chk("rst_err_ovf", bus.err_overflow, '0);
    chk("rst_err_tag", bus.err_rsp_tag, 1'b0);
    chk("rst3_err_tag", bus3.err_rsp_tag, 1'b0);
    pReset_n = 1'b1;

    // Single request on channel 2: visible two edges after it is driven.
    push(2, 64'hA5, 16'h0011, 1'b1);
    @(negedge pClk);
    clear_reqs();
    chk("single_lat1", bus.out_req_valid, 1'b0);
    @(negedge pClk);
    chk("single_lat2", bus.out_req_valid, 1'b1);
    chk("single_mdata", bus.out_req_mdata, 16'h8011);
    @(negedge pClk);
    chk("single_drop", bus.out_req_valid, 1'b0);
    chk("single_hold_hdr", bus.out_req_hdr, 64'hA5);

    // Fairness: 3 rounds of pushes on all channels, 12 back-to-back outputs 0,1,2,3,...
    do_reset();
    for (int ch = 0; ch < 4; ch++) push(ch, 64'(ch), 16'(ch), 1'b1);
    for (int n = 1; n <= 14; n++) begin
      @(negedge pClk);
      chk($sformatf("fair_valid_%0d", n), bus.out_req_valid, (n >= 2 && n <= 13));
      if (n < 3) begin
        for (int ch = 0; ch < 4; ch++) push(ch, 64'(256 * n + ch), 16'(16 * n + ch), 1'b1);
      end else begin
        clear_reqs();
      end
    end
    chk("fair_drained", 32'(exp_q.size()), 32'd0);

    // Backpressure: 5 requests, one already registered when almost-full rises.
    push(0, 64'hB0, 16'h00B0, 1'b1);
    push(1, 64'hB1, 16'h00B1, 1'b1);
    push(2, 64'hB2, 16'h00B2, 1'b1);
    @(negedge pClk);
    clear_reqs();
    chk("bp_pre", bus.out_req_valid, 1'b0);
    push(3, 64'hB3, 16'h00B3, 1'b1);
    push(0, 64'hB4, 16'h00B4, 1'b1);
    @(negedge pClk);
    clear_reqs();
    bus.out_almost_full = 1'b1;
    chk("bp_inflight", bus.out_req_valid, 1'b1);
    for (int n = 3; n <= 7; n++) begin
      @(negedge pClk);
      chk($sformatf("bp_hold_%0d", n), bus.out_req_valid, 1'b0);
    end
    bus.out_almost_full = 1'b0;
    for (int n = 8; n <= 11; n++) begin
      @(negedge pClk);
      chk($sformatf("bp_drain_%0d", n), bus.out_req_valid, 1'b1);
    end
    @(negedge pClk);
    chk("bp_idle", bus.out_req_valid, 1'b0);
    chk("bp_drained", 32'(exp_q.size()), 32'd0);

    // Fill channel 1 under backpressure; 9th push overflows and is dropped.
    bus.out_almost_full = 1'b1;
    for (int k = 0; k < 9; k++) begin
      push(1, 64'(32'hC00 + k), 16'(k), (k < 8));
      @(negedge pClk);
      clear_reqs();
      if (k == 4) chk("af_below", bus.ch_almost_full, 4'b0000);
      if (k == 5) chk("af_set", bus.ch_almost_full, 4'b0010);
      if (k == 7) chk("ovf_not_yet", bus.err_overflow, 4'b0000);
      if (k == 8) chk("ovf_set", bus.err_overflow, 4'b0010);
    end
    // Push coinciding with a pop while full is accepted.
    push(1, 64'hC09, 16'h0009, 1'b1);
    bus.out_almost_full = 1'b0;
    @(negedge pClk);
    clear_reqs();
    chk("full_pushpop_af", bus.ch_almost_full, 4'b0010);
    chk("full_pushpop_valid", bus.out_req_valid, 1'b1);
    for (int j = 1; j <= 8; j++) begin
      @(negedge pClk);
      chk($sformatf("full_drain_%0d", j), bus.out_req_valid, 1'b1);
    end
    @(negedge pClk);
    chk("full_idle", bus.out_req_valid, 1'b0);
    chk("full_drained", 32'(exp_q.size()), 32'd0);
    chk("ovf_sticky", bus.err_overflow, 4'b0010);

    // Response routing, back to back; bus3 has only 3 channels so tag 3 is illegal.
    d1 = {8{64'h0123_4567_89AB_CDEF}};
    d2 = {8{64'hFEDC_BA98_7654_3210}};
    d3 = {16{32'h5A5A_0003}};
    bus.rsp_valid  = 1'b1;
    bus.rsp_mdata  = 16'hC123;
    bus.rsp_data   = d1;
    bus3.rsp_valid = 1'b1;
    bus3.rsp_mdata = 16'h8005;
    bus3.rsp_data  = d3;
    @(negedge pClk);
    chk("rsp1_valid", bus.ch_rsp_valid, 4'b1000);
    chk("rsp1_mdata", bus.ch_rsp_mdata, 16'h0123);
    chk("rsp1_data", bus.ch_rsp_data, d1);
    chk("rsp3a_valid", bus3.ch_rsp_valid, 3'b100);
    chk("rsp3a_mdata", bus3.ch_rsp_mdata, 16'h0005);
    chk("rsp3a_err", bus3.err_rsp_tag, 1'b0);
    bus.rsp_mdata  = 16'h4ABC;
    bus.rsp_data   = d2;
    bus3.rsp_mdata = 16'hC000;
    @(negedge pClk);
    chk("rsp2_valid", bus.ch_rsp_valid, 4'b0010);
    chk("rsp2_mdata", bus.ch_rsp_mdata, 16'h0ABC);
    chk("rsp2_data", bus.ch_rsp_data, d2);
    chk("rsp3b_valid", bus3.ch_rsp_valid, 3'b000);
    chk("rsp3b_err", bus3.err_rsp_tag, 1'b1);
    bus.rsp_valid  = 1'b0;
    bus3.rsp_valid = 1'b0;
    @(negedge pClk);
    chk("rsp_idle_valid", bus.ch_rsp_valid, 4'b0000);
    chk("rsp_err_sticky", bus3.err_rsp_tag, 1'b1);
    chk("rsp_err_clean", bus.err_rsp_tag, 1'b0);

    // Reset with 3 requests queued: nothing issues, arbitration restarts at channel 0.
    bus.out_almost_full = 1'b1;
    push(1, 64'hD1, 16'h0001, 1'b0);
    push(2, 64'hD2, 16'h0002, 1'b0);
    push(3, 64'hD3, 16'h0003, 1'b0);
    @(negedge pClk);
    clear_reqs();
    chk("mid_blocked", bus.out_req_valid, 1'b0);
    bus.out_almost_full = 1'b0;
    do_reset();
    chk("mid_out_valid", bus.out_req_valid, 1'b0);
    chk("mid_out_hdr", bus.out_req_hdr, '0);
    chk("mid_out_mdata", bus.out_req_mdata, '0);
    chk("mid_err_ovf", bus.err_overflow, '0);
    chk("mid_ch_af", bus.ch_almost_full, '0);
    chk("mid_rsp_valid", bus.ch_rsp_valid, '0);
    chk("mid_rsp_mdata", bus.ch_rsp_mdata, '0);
    chk("mid_rsp_data", bus.ch_rsp_data, '0);
    chk("mid3_err_tag", bus3.err_rsp_tag, 1'b0);
    for (int n = 0; n < 3; n++) begin
      @(negedge pClk);
      chk($sformatf("mid_quiet_%0d", n), bus.out_req_valid, 1'b0);
    end
    push(0, 64'hE0, 16'h00E0, 1'b1);
    push(1, 64'hE1, 16'h00E1, 1'b1);
    push(3, 64'hE3, 16'h00E3, 1'b1);
    @(negedge pClk);
    clear_reqs();
    for (int n = 0; n < 3; n++) begin
      @(negedge pClk);
      chk($sformatf("mid_restart_%0d", n), bus.out_req_valid, 1'b1);
    end
    repeat (2) @(negedge pClk);
    chk("mid_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ccip_c0_req_mux.md
# ccip_c0_req_mux

Parametrised N-channel multiplexer for CCI-P C0 read requests. It sits between several requester sub-blocks inside the AFU top level and the single C0 Tx/Rx port toward the FIU, after any clock-crossing shim. Each channel gets its own request FIFO, and a round-robin arbiter merges the FIFOs while honouring the FIU almost-full backpressure. The channel ID is tagged into the upper mdata bits so that read responses are routed back to the issuing channel.

## Interface
- N_CH, 4: number of requester channels, 2..16
- HDR_W, 64: request header width (address, request type, etc.), carried opaquely
- MDATA_W, 16: mdata width; must exceed CH_W
- DATA_W, 512: response data width
- FIFO_DEPTH, 8: per-channel FIFO depth, power of 2, ≥4
- AF_SLACK, 2: free-slot margin at which ch_almost_full asserts
- Derived CH_W = max(1, $clog2(N_CH))

- pClk  in  1  clock
- pReset_n  in  1  reset, synchronous, active-low
- ch_req_valid  in  N_CH  per-channel push
- ch_req_hdr  in  N_CH*HDR_W  per-channel header; channel i in slice i
- ch_req_mdata  in  N_CH*MDATA_W  per-channel mdata; channels use only the low MDATA_W-CH_W bits
- ch_almost_full  out  N_CH  FIFO occupancy ≥ FIFO_DEPTH-AF_SLACK
- out_req_valid  out  1  merged request valid, registered
- out_req_hdr  out  HDR_W  merged header
- out_req_mdata  out  MDATA_W  mdata with the channel ID in bits [MDATA_W-1 -: CH_W]
- out_almost_full  in  1  FIU C0 Tx almost-full
- rsp_valid  in  1  C0 read response valid
- rsp_mdata  in  MDATA_W  response mdata
- rsp_data  in  DATA_W  response data
- ch_rsp_valid  out  N_CH  routed response valid, one-hot or zero
- ch_rsp_mdata  out  MDATA_W  shared; tag bits cleared
- ch_rsp_data  out  DATA_W  shared
- err_overflow  out  N_CH  sticky; push while FIFO full and not popping
- err_rsp_tag  out  1  sticky; response tag ≥ N_CH

## Operation
- **Reset** (pReset_n=0 at a pClk edge): all FIFOs empty, rr_ptr=0, and every output 0, including the error flags. Reset mid-operation discards queued requests; no partial request is emitted.
- **Push.** Channel i writes when ch_req_valid[i] is high.
  - Accepted if count<FIFO_DEPTH, or if the FIFO is full and popped in the same cycle.
  - Otherwise the push is dropped and err_overflow[i] is set.
  - Pointers wrap modulo FIFO_DEPTH.
- **Arbitration.** Evaluated each cycle.
  - Eligible when out_almost_full=0 and at least one FIFO is non-empty.
  - Grant goes to the first non-empty channel at index rr_ptr, rr_ptr+1, … (mod N_CH).
  - The granted entry is popped, and rr_ptr becomes (grant+1) mod N_CH.
  - With no grant, rr_ptr holds.
- **Output.** On a grant, the output registers load next cycle: out_req_valid=1, out_req_hdr=hdr, out_req_mdata={grant[CH_W-1:0], mdata[MDATA_W-CH_W-1:0]}. With no grant, out_req_valid=0 and hdr/mdata hold.
- **Backpressure.** While out_almost_full=1, no grant occurs. The at most one request already registered still issues; this fits within the FIU slack.
- **Simultaneous push and pop on the same FIFO:** count is unchanged.
- **ch_almost_full[i]** is a combinational compare on the registered count.
- **Response routing** (stateless):
  - ch = rsp_mdata[MDATA_W-1 -: CH_W].
  - If ch<N_CH: the next cycle has ch_rsp_valid[ch]=1, ch_rsp_mdata = rsp_mdata with the tag bits zeroed, ch_rsp_data = rsp_data.
  - If ch≥N_CH: the response is dropped and err_rsp_tag is set.
  - Routing is unaffected by request-side state. Responses arriving after reset deassertion are still routed.

## Timing
- **Request latency:** a push into an empty FIFO at edge t, with no contention and out_almost_full=0, gives out_req_valid=1 after edge t+2.
- **Throughput:** one request per cycle aggregate. Under full load each of k active channels is served once every k cycles.
- **Response latency:** 1 cycle, registered; one response per cycle.
- **out_almost_full** is sampled at the same edge as the grant decision. A rise at edge t blocks grants from edge t onward.
- **Flow control:** no combinational path from out_almost_full to out_req_*. ch_almost_full depends only on registers.

## Test plan
- **Single request.** N_CH=4. Channel 2 pushes hdr=0xA5, mdata=0x0011 at t0. Required: out_req_valid at t0+2 with mdata=0x8011, then valid drops.
- **Fairness.** All 4 channels each push 3 requests in consecutive cycles. Required: output channel order 0,1,2,3,0,1,2,3,0,1,2,3 with no idle cycles once started.
- **Backpressure.** out_almost_full=1 with 5 queued requests. Required: at most 1 out_req_valid after assertion, then none. After deassertion, the remaining requests drain in round-robin order.
- **FIFO full / overflow.** FIFO_DEPTH=8, AF_SLACK=2, out_almost_full=1.
  - 6 pushes set ch_almost_full[1].
  - The 9th push sets err_overflow[1]; count stays 8.
  - A push coinciding with a pop when full is accepted.
- **Response routing.** rsp_mdata=0xC123 gives ch_rsp_valid=4'b1000 next cycle with ch_rsp_mdata=0x0123. With N_CH=3, rsp_mdata=0xC000 gives no valid and err_rsp_tag=1.
- **Reset mid-operation.** pReset_n=0 for 1 cycle with 3 requests queued. Required: all outputs 0, no queued request issued, rr_ptr restarts at channel 0.
